// File: rtl/datapath.sv
// rtl/datapath.sv - 32-bit single-bus CPU datapath: registers, bus encoder/mux and ALU
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R3out,
  input  logic             R7out,
  input  logic             MARin,
  input  logic             Zin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R7in,
  input  logic             Clock,
  input  logic             R2out,
  input  logic             R1out,
  input  logic             R0out,
  input  logic             R6out,
  input  logic             R5out,
  input  logic             R4out,
  input  logic             ZHighout,
  input  logic             LOout,
  input  logic             HIout,
  input  logic             R15out,
  input  logic             R14out,
  input  logic             R13out,
  input  logic             R12out,
  input  logic             R11out,
  input  logic             R10out,
  input  logic             R9out,
  input  logic             R8out,
  input  logic             Cout,
  input  logic             InPortout,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [4:0]       operation,
  output logic [WIDTH-1:0] encoder_input,
  input  logic             Resetn
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [WIDTH-1:0]   r3_q, r3_d, r4_q, r4_d, r7_q, r7_d;
  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d, y_q, y_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   encoder_in;
  logic [4:0]         encoder_out;
  logic [WIDTH-1:0]   bus_data;
  logic [WIDTH-1:0]   mdr_out, zlow_out, zhigh_out;
  logic [2*WIDTH-1:0] alu_res;

  // MAR and IR feed later stages only; AND is a reserved strobe
  logic unused_ok;
  assign unused_ok = &{1'b0, AND, mar_q, ir_q};

  assign mdr_out   = mdr_q;
  assign zlow_out  = z_q[WIDTH-1:0];
  assign zhigh_out = z_q[2*WIDTH-1:WIDTH];

  // Bus request vector: bit i is the drive strobe of source i
  assign encoder_in = {{(WIDTH-24){1'b0}}, Cout, InPortout, MDRout, PCout, Zlowout,
                       ZHighout, LOout, HIout,
                       R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                       R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign encoder_input = encoder_in;

  // Priority encoder: lowest asserted index wins, 31 when idle
  always_comb begin
    encoder_out = 5'd31;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (encoder_in[i]) encoder_out = 5'(i);
    end
  end

  // Bus multiplexer; sources without a load path read as zero
  always_comb begin
    bus_data = '0;
    case (encoder_out)
      5'd3:    bus_data = r3_q;
      5'd4:    bus_data = r4_q;
      5'd7:    bus_data = r7_q;
      5'd18:   bus_data = zhigh_out;
      5'd19:   bus_data = zlow_out;
      5'd20:   bus_data = pc_q;
      5'd21:   bus_data = mdr_q;
      default: bus_data = '0;
    endcase
  end

  // ALU: A = Y, B = bus; IncPC overrides the opcode
  always_comb begin
    logic [WIDTH-1:0]   a, b, lo, hi;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] ror_w, rol_w, a_ext, b_ext;
    a     = y_q;
    b     = bus_data;
    amt   = b[SHW-1:0];
    ror_w = {a, a} >> amt;
    rol_w = {a, a} << amt;
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    lo    = '0;
    hi    = '0;
    alu_res = '0;
    if (IncPC) begin
      lo = b + ONE;
      alu_res = {hi, lo};
    end else begin
      case (operation)
        OP_ADD:  lo = a + b;
        OP_SUB:  lo = a - b;
        OP_SHR:  lo = a >> amt;
        OP_SHRA: lo = $signed(a) >>> amt;
        OP_SHL:  lo = a << amt;
        OP_ROR:  lo = ror_w[WIDTH-1:0];
        OP_ROL:  lo = rol_w[2*WIDTH-1:WIDTH];
        OP_AND:  lo = a & b;
        OP_OR:   lo = a | b;
        OP_NEG:  lo = '0 - b;
        OP_NOT:  lo = ~b;
        OP_MUL:  {hi, lo} = a_ext * b_ext;
        OP_DIV: begin
          if (b != '0) begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
          end
        end
        default: lo = '0;
      endcase
      alu_res = {hi, lo};
    end
  end

  // Register next-state: each enabled register captures the bus (MDR and Z differ)
  always_comb begin
    r3_d  = r3_q;
    r4_d  = r4_q;
    r7_d  = r7_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    z_d   = z_q;
    if (R3in)  r3_d  = bus_data;
    if (R4in)  r4_d  = bus_data;
    if (R7in)  r7_d  = bus_data;
    if (PCin)  pc_d  = bus_data;
    if (IRin)  ir_d  = bus_data;
    if (MARin) mar_d = bus_data;
    if (Yin)   y_d   = bus_data;
    if (MDRin) mdr_d = Read ? Mdatain : bus_data;
    if (Zin)   z_d   = alu_res;
  end

  // Storage with asynchronous active-low clear
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r3_q  <= '0;
      r4_q  <= '0;
      r7_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      r7_q  <= r7_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed self-checking bench for datapath
module tb_datapath;

  logic PCout, Zlowout, MDRout, R3out, R7out, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic IncPC, Read, AND, R3in, R4in, R7in, Clock;
  logic R2out, R1out, R0out, R6out, R5out, R4out, ZHighout, LOout, HIout;
  logic R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out, Cout, InPortout;
  logic [31:0] Mdatain;
  logic [4:0]  operation;
  logic [31:0] encoder_input;
  logic        Resetn;

  int vectors = 0;
  int miscompares = 0;

  datapath dut (
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R3out(R3out), .R7out(R7out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .AND(AND), .R3in(R3in), .R4in(R4in), .R7in(R7in),
    .Clock(Clock), .R2out(R2out), .R1out(R1out), .R0out(R0out), .R6out(R6out),
    .R5out(R5out), .R4out(R4out), .ZHighout(ZHighout), .LOout(LOout), .HIout(HIout),
    .R15out(R15out), .R14out(R14out), .R13out(R13out), .R12out(R12out),
    .R11out(R11out), .R10out(R10out), .R9out(R9out), .R8out(R8out), .Cout(Cout),
    .InPortout(InPortout), .Mdatain(Mdatain), .operation(operation),
    .encoder_input(encoder_input), .Resetn(Resetn)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic clear_inputs;
    {PCout, Zlowout, MDRout, R3out, R7out, MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
    {IncPC, Read, AND, R3in, R4in, R7in} = '0;
    {R2out, R1out, R0out, R6out, R5out, R4out, ZHighout, LOout, HIout} = '0;
    {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out, Cout, InPortout} = '0;
    Mdatain = '0;
    operation = '0;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    clear_inputs();
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    clear_inputs();
  endtask

  task automatic set_operands(input logic [31:0] a, input logic [31:0] b);
    load_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    clear_inputs();
    load_mdr(b);
  endtask

  task automatic run_op(input logic [4:0] op, input logic inc);
    MDRout = 1; Zin = 1; operation = op; IncPC = inc;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset;
    logic [63:0] obs [9];
    clear_inputs();
    Resetn = 1;
    #2 Resetn = 0;
    tick();
    tick();
    obs = '{64'(dut.r3_q), 64'(dut.r4_q), 64'(dut.r7_q), 64'(dut.pc_q), 64'(dut.ir_q),
            64'(dut.mar_q), 64'(dut.mdr_out), 64'(dut.y_q), {dut.zhigh_out, dut.zlow_out}};
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (obs[i] !== 64'h0) begin
        miscompares++;
        $display("FAIL reset_reg%0d got %h want 0", i, obs[i]);
      end
    end
    vectors++;
    if (dut.bus_data !== 32'h0) begin
      miscompares++; $display("FAIL reset_bus got %h want 0", dut.bus_data);
    end
    vectors++;
    if (encoder_input !== 32'h0) begin
      miscompares++; $display("FAIL reset_encoder_input got %h want 0", encoder_input);
    end
    vectors++;
    if (dut.encoder_out !== 5'd31) begin
      miscompares++; $display("FAIL reset_encoder_out got %0d want 31", dut.encoder_out);
    end
    #3 Resetn = 1;
    tick();
  endtask

  task automatic test_reg_loads;
    logic [31:0] vals [3] = '{32'h22, 32'h24, 32'h28};
    logic [31:0] got;
    for (int i = 0; i < 3; i++) begin
      load_mdr(vals[i]);
      MDRout = 1;
      case (i)
        0: R3in = 1;
        1: R7in = 1;
        default: R4in = 1;
      endcase
      tick();
      clear_inputs();
    end
    for (int i = 0; i < 3; i++) begin
      got = (i == 0) ? dut.r3_q : (i == 1) ? dut.r7_q : dut.r4_q;
      vectors++;
      if (got !== vals[i]) begin
        miscompares++; $display("FAIL reg_load%0d got %h want %h", i, got, vals[i]);
      end
    end
  endtask

  task automatic test_fetch;
    MDRout = 1; MARin = 1;
    tick();
    clear_inputs();
    vectors++;
    if (dut.mar_q !== 32'h28) begin
      miscompares++; $display("FAIL fetch_mar_preload got %h want 28", dut.mar_q);
    end
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; MDRout = 1;
    #1;
    vectors++;
    if (dut.bus_data !== 32'h0) begin
      miscompares++; $display("FAIL fetch_bus_priority got %h want 0", dut.bus_data);
    end
    vectors++;
    if (encoder_input !== 32'h0030_0000) begin
      miscompares++; $display("FAIL fetch_encoder_input got %h want 00300000", encoder_input);
    end
    tick();
    clear_inputs();
    vectors++;
    if (dut.mar_q !== 32'h0) begin
      miscompares++; $display("FAIL fetch_mar got %h want 0", dut.mar_q);
    end
    vectors++;
    if ({dut.zhigh_out, dut.zlow_out} !== 64'h1) begin
      miscompares++; $display("FAIL fetch_z got %h want 1", {dut.zhigh_out, dut.zlow_out});
    end
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2A2B_8000;
    tick();
    clear_inputs();
    vectors++;
    if (dut.pc_q !== 32'h1) begin
      miscompares++; $display("FAIL fetch_pc got %h want 1", dut.pc_q);
    end
    vectors++;
    if (dut.mdr_out !== 32'h2A2B_8000) begin
      miscompares++; $display("FAIL fetch_mdr got %h want 2a2b8000", dut.mdr_out);
    end
    MDRout = 1; IRin = 1;
    tick();
    clear_inputs();
    vectors++;
    if (dut.ir_q !== 32'h2A2B_8000) begin
      miscompares++; $display("FAIL fetch_ir got %h want 2a2b8000", dut.ir_q);
    end
  endtask

  task automatic test_sub;
    R3out = 1; R7out = 1; Yin = 1;
    #1;
    vectors++;
    if (dut.bus_data !== 32'h22) begin
      miscompares++; $display("FAIL sub_bus_r3_priority got %h want 22", dut.bus_data);
    end
    tick();
    clear_inputs();
    vectors++;
    if (dut.y_q !== 32'h22) begin
      miscompares++; $display("FAIL sub_y got %h want 22", dut.y_q);
    end
    R7out = 1; Zin = 1; operation = 5'b00100;
    tick();
    clear_inputs();
    vectors++;
    if ({dut.zhigh_out, dut.zlow_out} !== 64'h0000_0000_FFFF_FFFE) begin
      miscompares++; $display("FAIL sub_z got %h want 00000000fffffffe", {dut.zhigh_out, dut.zlow_out});
    end
    Zlowout = 1; R4in = 1;
    tick();
    clear_inputs();
    vectors++;
    if (dut.r4_q !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL sub_r4 got %h want fffffffe", dut.r4_q);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        inc;
    logic [63:0] exp;
  } vec_t;

  task automatic run_table(input string name, input vec_t tbl [$]);
    for (int i = 0; i < tbl.size(); i++) begin
      set_operands(tbl[i].a, tbl[i].b);
      run_op(tbl[i].op, tbl[i].inc);
      vectors++;
      if ({dut.zhigh_out, dut.zlow_out} !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL %s[%0d] op=%b got %h want %h", name, i, tbl[i].op,
                 {dut.zhigh_out, dut.zlow_out}, tbl[i].exp);
      end
    end
  endtask

  task automatic test_muldiv;
    vec_t tbl [$];
    tbl.push_back('{32'hFFFF_FFFD, 32'h7,         5'b01111, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
    tbl.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'b01111, 1'b0, 64'h3FFF_FFFF_0000_0001});
    tbl.push_back('{32'h7,         32'h2,         5'b10000, 1'b0, 64'h0000_0001_0000_0003});
    tbl.push_back('{32'h7,         32'h0,         5'b10000, 1'b0, 64'h0});
    tbl.push_back('{32'hFFFF_FFF9, 32'h2,         5'b10000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    run_table("muldiv", tbl);
  endtask

  task automatic test_alu_ops;
    vec_t tbl [$];
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b00011, 1'b0, 64'h8000_0015});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b00101, 1'b0, 64'h0800_0001});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b00110, 1'b0, 64'hF800_0001});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b00111, 1'b0, 64'h0000_0110});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b01000, 1'b0, 64'h1800_0001});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b01001, 1'b0, 64'h0000_0118});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b01010, 1'b0, 64'h0});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b01011, 1'b0, 64'h8000_0015});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b10001, 1'b0, 64'hFFFF_FFFC});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b10010, 1'b0, 64'hFFFF_FFFB});
    tbl.push_back('{32'h8000_0011, 32'h4,  5'b11111, 1'b0, 64'h0});
    tbl.push_back('{32'hFFFF_FFFF, 32'h1,  5'b00011, 1'b0, 64'h0});
    tbl.push_back('{32'h1,         32'h24, 5'b00111, 1'b0, 64'h10});
    tbl.push_back('{32'h5,         32'h10, 5'b01111, 1'b1, 64'h11});
    run_table("alu", tbl);
  endtask

  task automatic test_async_reset;
    load_mdr(32'h55);
    MDRout = 1; R3in = 1; PCin = 1; Zin = 1; IncPC = 1;
    tick();
    clear_inputs();
    #1 Zlowout = 1; R4in = 1;
    #1 Resetn = 0;
    #1;
    vectors++;
    if ({dut.r3_q, dut.pc_q, dut.zlow_out, dut.mdr_out} !== 128'h0) begin
      miscompares++;
      $display("FAIL async_reset_immediate got r3=%h pc=%h zlow=%h mdr=%h want 0",
               dut.r3_q, dut.pc_q, dut.zlow_out, dut.mdr_out);
    end
    tick();
    vectors++;
    if ({dut.r3_q, dut.r4_q, dut.pc_q, dut.zlow_out} !== 128'h0) begin
      miscompares++;
      $display("FAIL async_reset_hold got r3=%h r4=%h pc=%h zlow=%h want 0",
               dut.r3_q, dut.r4_q, dut.pc_q, dut.zlow_out);
    end
    #4 Resetn = 1;
    clear_inputs();
    load_mdr(32'h77);
    vectors++;
    if (dut.mdr_out !== 32'h77) begin
      miscompares++; $display("FAIL async_reset_release_mdr got %h want 77", dut.mdr_out);
    end
  endtask

  initial begin
    test_reset();
    test_reg_loads();
    test_fetch();
    test_sub();
    test_muldiv();
    test_alu_ops();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
